// File: rtl/branch_resolve_unit_if.sv
// Branch resolve bus: EX-stage branch inputs plus redirect, flush and CCR control outputs.
interface branch_resolve_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              br_valid;
  logic [2:0]        br_type;
  logic [ADDR_W-1:0] br_target;
  logic [3:0]        current_flags;
  logic              stall_in;
  logic              int_req;
  logic              pc_redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              clr_flags_en;
  logic [3:0]        clr_flags_mask;
  logic              restore_flags_en;
  logic [3:0]        restore_flags;
  logic [3:0]        saved_flags;
  logic              busy;

  modport master (
    output br_valid, br_type, br_target, current_flags, stall_in, int_req,
    input  pc_redirect, redirect_addr, flush_if_id, flush_id_ex, clr_flags_en,
           clr_flags_mask, restore_flags_en, restore_flags, saved_flags, busy
  );

  modport slave (
    input  br_valid, br_type, br_target, current_flags, stall_in, int_req,
    output pc_redirect, redirect_addr, flush_if_id, flush_id_ex, clr_flags_en,
           clr_flags_mask, restore_flags_en, restore_flags, saved_flags, busy
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches against forwarded flags, redirects fetch, sequences the
// front-end flush and manages single-level flag save/restore for INT/RTI.
module branch_resolve_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned CNT_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [2:0] BR_JZ  = 3'b000;
  localparam logic [2:0] BR_JN  = 3'b001;
  localparam logic [2:0] BR_JC  = 3'b010;
  localparam logic [2:0] BR_JMP = 3'b011;
  localparam logic [2:0] BR_CAL = 3'b100;
  localparam logic [2:0] BR_RET = 3'b101;
  localparam logic [2:0] BR_RTI = 3'b110;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              clr_en_q, clr_en_d;
  logic [3:0]        clr_mask_q, clr_mask_d;
  logic              restore_en_q, restore_en_d;
  logic [3:0]        restore_q, restore_d;
  logic [3:0]        saved_q, saved_d;
  logic              saved_valid_q, saved_valid_d;
  logic              taken_c;
  logic [3:0]        cond_mask_c;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    addr_d        = addr_q;
    clr_en_d      = 1'b0;
    clr_mask_d    = 4'b0000;
    restore_en_d  = 1'b0;
    restore_d     = restore_q;
    saved_d       = saved_q;
    saved_valid_d = saved_valid_q;
    taken_c       = 1'b0;
    cond_mask_c   = 4'b0000;

    case (bus.br_type)
      BR_JZ:  begin taken_c = bus.current_flags[0]; cond_mask_c = 4'b0001; end
      BR_JN:  begin taken_c = bus.current_flags[1]; cond_mask_c = 4'b0010; end
      BR_JC:  begin taken_c = bus.current_flags[2]; cond_mask_c = 4'b0100; end
      BR_JMP, BR_CAL, BR_RET, BR_RTI: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.br_valid && !bus.stall_in && taken_c) begin
          state_d    = FLUSH;
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          redirect_d = 1'b1;
          addr_d     = bus.br_target;
          clr_en_d   = |cond_mask_c;
          clr_mask_d = cond_mask_c;
          if (bus.br_type == BR_RTI) begin
            restore_en_d  = 1'b1;
            restore_d     = saved_q;
            saved_valid_d = 1'b0;
          end
        end
      end
      default: begin
        // Shadow branches are ignored; stall does not freeze the countdown
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Interrupt save wins over an RTI clearing saved_valid on the same edge
    if (bus.int_req) begin
      saved_d       = bus.current_flags & ~clr_mask_d;
      saved_valid_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      addr_q        <= '0;
      clr_en_q      <= 1'b0;
      clr_mask_q    <= 4'b0000;
      restore_en_q  <= 1'b0;
      restore_q     <= 4'b0000;
      saved_q       <= 4'b0000;
      saved_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      addr_q        <= addr_d;
      clr_en_q      <= clr_en_d;
      clr_mask_q    <= clr_mask_d;
      restore_en_q  <= restore_en_d;
      restore_q     <= restore_d;
      saved_q       <= saved_d;
      saved_valid_q <= saved_valid_d;
    end
  end

  assign bus.pc_redirect      = redirect_q;
  assign bus.redirect_addr    = addr_q;
  assign bus.flush_if_id      = (state_q == FLUSH);
  assign bus.flush_id_ex      = (state_q == FLUSH);
  assign bus.busy             = (state_q == FLUSH);
  assign bus.clr_flags_en     = clr_en_q;
  assign bus.clr_flags_mask   = clr_mask_q;
  assign bus.restore_flags_en = restore_en_q;
  assign bus.restore_flags    = restore_q;
  assign bus.saved_flags      = saved_q;
endmodule
